// File: rtl/btn_debounce.sv
// Push-button conditioner: a two-flop synchronizer per channel feeding a four-state debounce FSM.
// Outputs a bounce-free level plus registered one-cycle press/release pulses per button.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE_LOW  | accepted level 0, input agrees, counter held at 0
// WAIT_HIGH | accepted level 0, input high, counting toward acceptance
// IDLE_HIGH | accepted level 1, input agrees, counter held at 0
// WAIT_LOW  | accepted level 1, input low, counting toward acceptance
module btn_debounce #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNTR_WIDTH      = 18
) (
    input  logic               Bus2IP_Clk,
    input  logic               Bus2IP_Reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_db,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } db_state_t;

    // The counter tops out at DEBOUNCE_CYCLES-1, so it must fit in CNTR_WIDTH bits.
    if ((DEBOUNCE_CYCLES < 2) ||
        (longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNTR_WIDTH))) begin : g_bad_param
        $error("btn_debounce: DEBOUNCE_CYCLES must lie in 2..2**CNTR_WIDTH");
    end

    localparam logic [CNTR_WIDTH-1:0] CNT_LAST = CNTR_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = CNTR_WIDTH'(1);

    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        db_state_t             state_q, state_d;
        logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
        logic                  db_q, db_d;
        logic                  press_q, press_d;
        logic                  release_q, release_d;
        logic                  in_s;

        assign in_s = sync2_q[i];

        always_comb begin
            state_d   = state_q;
            cnt_d     = '0;
            db_d      = db_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (in_s) begin
                        state_d = WAIT_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!in_s) begin
                        state_d = IDLE_LOW;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_HIGH;
                        db_d    = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!in_s) begin
                        state_d = WAIT_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    if (in_s) begin
                        state_d = IDLE_HIGH;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE_LOW;
                        db_d      = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    db_d    = 1'b0;
                end
            endcase
        end

        always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
            if (Bus2IP_Reset) begin
                state_q   <= IDLE_LOW;
                cnt_q     <= '0;
                db_q      <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                db_q      <= db_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_db[i]      = db_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed edge-exact scenarios plus random stimulus, all checked
// against a run-length model of the accepted level per button.
module tb_btn_debounce;

    localparam int NB = 3;
    localparam int DB = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_db;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int n_total = 0;
    int n_bad   = 0;

    btn_debounce #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .CNTR_WIDTH     (CW)
    ) dut (
        .Bus2IP_Clk  (clk),
        .Bus2IP_Reset(rst),
        .btn_raw     (btn_raw),
        .btn_db      (btn_db),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: two-sample delay, then a new level is accepted once DB consecutive
    // samples disagree with the current level; any agreeing sample clears the run.
    logic [NB-1:0] m_s1  = '0;
    logic [NB-1:0] m_s2  = '0;
    logic [NB-1:0] m_lvl = '0;
    logic [NB-1:0] m_pr  = '0;
    logic [NB-1:0] m_rl  = '0;
    int            m_run [NB] = '{default: 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1  <= '0;
            m_s2  <= '0;
            m_lvl <= '0;
            m_pr  <= '0;
            m_rl  <= '0;
            for (int i = 0; i < NB; i++) m_run[i] <= 0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (m_s2[i] != m_lvl[i] && m_run[i] + 1 == DB) begin
                    m_lvl[i] <= m_s2[i];
                    m_pr[i]  <= m_s2[i];
                    m_rl[i]  <= ~m_s2[i];
                    m_run[i] <= 0;
                end else begin
                    m_pr[i]  <= 1'b0;
                    m_rl[i]  <= 1'b0;
                    m_run[i] <= (m_s2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
                end
            end
            m_s2 <= m_s1;
            m_s1 <= btn_raw;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mdl_db", btn_db, m_lvl);
            chk("mdl_press", btn_press, m_pr);
            chk("mdl_release", btn_release, m_rl);
        end
    end

    // Drive raw between edges; the change lands before edge 1, so outputs move at edge 10.
    task automatic qual(input string tag, input logic [NB-1:0] raw_v,
                        input logic [NB-1:0] db0, input logic [NB-1:0] db1,
                        input logic [NB-1:0] pr, input logic [NB-1:0] rl);
        @(negedge clk); #1;
        btn_raw = raw_v;
        for (int j = 1; j <= 14; j++) begin
            @(posedge clk); #1;
            chk({tag, "_db"}, btn_db, (j >= DB + 2) ? db1 : db0);
            chk({tag, "_press"}, btn_press, (j == DB + 2) ? pr : '0);
            chk({tag, "_release"}, btn_release, (j == DB + 2) ? rl : '0);
        end
    endtask

    initial begin
        logic [NB-1:0] jc;
        logic [NB-1:0] rv;
        int            hold [NB];

        repeat (3) @(posedge clk);
        #1;
        chk("rst_db", btn_db, '0);
        chk("rst_press", btn_press, '0);
        chk("rst_release", btn_release, '0);
        @(negedge clk); #1;
        rst = 1'b0;

        qual("clean", 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);
        qual("press2", 3'b101, 3'b001, 3'b101, 3'b100, 3'b000);
        qual("release2", 3'b001, 3'b101, 3'b001, 3'b000, 3'b100);

        @(negedge clk); #1;
        btn_raw = 3'b011;
        repeat (DB - 1) begin
            @(posedge clk); #1;
            chk("glitch_db", btn_db, 3'b001);
            chk("glitch_press", btn_press, 3'b000);
        end
        @(negedge clk); #1;
        btn_raw = 3'b001;
        @(posedge clk); #1;
        chk("glitch_low_db", btn_db, 3'b001);
        qual("bounce", 3'b011, 3'b001, 3'b011, 3'b010, 3'b000);

        qual("rel_all", 3'b000, 3'b011, 3'b000, 3'b000, 3'b011);
        qual("simul", 3'b111, 3'b000, 3'b111, 3'b111, 3'b000);
        qual("simul_rel", 3'b000, 3'b111, 3'b000, 3'b000, 3'b111);

        qual("pre_rst", 3'b001, 3'b000, 3'b001, 3'b001, 3'b000);
        @(negedge clk); #1;
        btn_raw = 3'b011;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_db", btn_db, 3'b000);
        chk("rst_async_press", btn_press, 3'b000);
        chk("rst_async_release", btn_release, 3'b000);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            @(posedge clk); #1;
            chk("post_rst_db", btn_db, (j >= DB + 2) ? 3'b011 : 3'b000);
            chk("post_rst_press", btn_press, (j == DB + 2) ? 3'b011 : 3'b000);
            chk("post_rst_release", btn_release, 3'b000);
        end
        qual("post_rst_rel", 3'b000, 3'b011, 3'b000, 3'b000, 3'b011);

        jc = '0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk); #1;
            btn_raw = jc;
            jc = {jc[NB-2:0], ~jc[NB-1]};
            @(posedge clk); #1;
            chk("johnson_db", btn_db, 3'b000);
            chk("johnson_press", btn_press, 3'b000);
            chk("johnson_release", btn_release, 3'b000);
        end
        @(negedge clk); #1;
        btn_raw = '0;
        repeat (DB + 4) @(posedge clk);

        rv = '0;
        for (int i = 0; i < NB; i++) hold[i] = $urandom_range(1, 14);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            for (int i = 0; i < NB; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    rv[i]   = ~rv[i];
                    hold[i] = $urandom_range(1, 14);
                end
            end
            btn_raw = rv;
        end
        repeat (DB + 6) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
